rr_arbiter8: RTL and testbench

//   8-way round-robin arbiter that shares one 3-to-8 decoded resource

---
 rtl/rr_arbiter8_if.sv | 37 +++
 rtl/rr_arbiter8.sv | 117 +++++++++++
 tb/tb_rr_arbiter8.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_if
//  Description : Bus bundle between the requester pool and rr_arbiter8.
//                master = requester side (drives enable/req/rel).
//                slave  = arbiter side (drives grant/grant_idx/grant_valid/
//                         timeout).
//  Signals     : enable       arbiter enable
//                req[7:0]     request vector, bit i = requester i
//                rel          owner done, ends the current grant
//                               ("release" is a reserved SV keyword)
//                grant[7:0]   one-hot grant
//                grant_idx    index of current owner (decoder data_in)
//                grant_valid  grant active (decoder enable)
//                timeout      one-cycle pulse, grant ended by hold expiry
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_arbiter8_if;
    logic       enable;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output enable, req, rel,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  enable, req, rel,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : 8-way round-robin arbiter in front of a 3-to-8 decoder.
//                Grants are held until the owner releases, drops its request,
//                the arbiter is disabled, or the hold limit expires. Priority
//                then rotates to the requester after the last owner. One idle
//                cycle always separates consecutive grants.
//  Parameters  : MAX_HOLD  max cycles a grant may be held (0 = unlimited)
//                CNT_W     hold counter width, MAX_HOLD <= 2**CNT_W-1
//  Ports       : clk       clock, rising edge
//                reset     synchronous active-high reset
//                bus       rr_arbiter8_if.slave (enable, req, rel in;
//                          grant, grant_idx, grant_valid, timeout out)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         reset,
    rr_arbiter8_if.slave bus
);

    localparam logic             c_TIMEOUT_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] c_MAX_HOLD_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_CNT_SAT      = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [7:0]       r_grant;
    logic [2:0]       r_grant_idx;
    logic             r_grant_valid;
    logic             r_timeout;

    logic [2:0]       w_winner;
    logic [2:0]       w_scan;
    logic             w_found;
    logic             w_owner_done;
    logic             w_expired;
    logic             w_end;

    // Rotating priority scan: the first requester at or after r_ptr wins.
    always_comb begin
        w_winner = r_ptr;
        w_scan   = r_ptr;
        w_found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_scan = r_ptr + 3'(i);
            if (!w_found && bus.req[w_scan]) begin
                w_winner = w_scan;
                w_found  = 1'b1;
            end
        end
    end

    // Owner-driven ends take precedence over expiry when deciding timeout.
    assign w_owner_done = bus.rel | ~bus.req[r_grant_idx] | ~bus.enable;
    assign w_expired    = c_TIMEOUT_EN && (r_hold_cnt == c_MAX_HOLD_CNT);
    assign w_end        = w_owner_done | w_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= 3'd0;
            r_hold_cnt    <= '0;
            r_grant       <= 8'h00;
            r_grant_idx   <= 3'd0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.enable && (|bus.req)) begin
                        r_state       <= GRANT;
                        r_grant_idx   <= w_winner;
                        r_grant       <= 8'd1 << w_winner;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (w_end) begin
                        r_state       <= IDLE;
                        r_ptr         <= r_grant_idx + 3'd1;
                        r_grant       <= 8'h00;
                        r_grant_idx   <= 3'd0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_timeout     <= w_expired & ~w_owner_done;
                    end else if (r_hold_cnt != c_CNT_SAT) begin
                        // Saturate instead of wrapping when the limit is off.
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_grant_idx;
    assign bus.grant_valid = r_grant_valid;
    assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Self-checking bench for rr_arbiter8 (MAX_HOLD=3). A cycle
//                model fills an expectation queue on every rising edge; the
//                falling edge pops and compares. Directed checks with fixed
//                values cover reset, single request, wrap, timeout, abort
//                and rotation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter8;

    localparam int c_MAX_HOLD = 3;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    rr_arbiter8_if bus ();

    rr_arbiter8 #(
        .MAX_HOLD (c_MAX_HOLD),
        .CNT_W    (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, state kept as plain integers.
    int   m_valid;
    int   m_idx;
    int   m_ptr;
    int   m_cnt;
    int   m_to;
    int   m_done;
    int   m_exp;
    exp_t m_e;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_valid == 0) begin
                if (bus.enable && bus.req != 8'h00) begin
                    for (int k = 7; k >= 0; k--) begin
                        if (bus.req[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
                    end
                    m_valid = 1;
                    m_cnt   = 1;
                end
            end else begin
                m_done = (bus.rel || !bus.req[m_idx] || !bus.enable) ? 1 : 0;
                m_exp  = (c_MAX_HOLD != 0 && m_cnt == c_MAX_HOLD) ? 1 : 0;
                if (m_done != 0 || m_exp != 0) begin
                    m_ptr   = (m_idx + 1) % 8;
                    m_to    = (m_done == 0) ? 1 : 0;
                    m_valid = 0;
                    m_idx   = 0;
                    m_cnt   = 0;
                end else if (m_cnt < 15) begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        m_e.grant = (m_valid != 0) ? (8'd1 << m_idx) : 8'h00;
        m_e.idx   = 3'(m_idx);
        m_e.valid = (m_valid != 0);
        m_e.to    = (m_to != 0);
        sb_q.push_back(m_e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_grant", 32'(bus.grant), 32'(e.grant));
            check_eq("sb_idx", 32'(bus.grant_idx), 32'(e.idx));
            check_eq("sb_valid", 32'(bus.grant_valid), 32'(e.valid));
            check_eq("sb_timeout", 32'(bus.timeout), 32'(e.to));
        end
    end

    // Inputs change just after the falling edge.
    task automatic drive(input logic rs, input logic en, input logic [7:0] rq, input logic rl);
        @(negedge clk);
        #1;
        reset      = rs;
        bus.enable = en;
        bus.req    = rq;
        bus.rel    = rl;
    endtask

    // Observe outputs just after the rising edge that consumes the drive.
    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                              input logic v, input logic to);
        @(posedge clk);
        #1;
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'(g));
        check_eq({tag, "_idx"}, 32'(bus.grant_idx), 32'(idx));
        check_eq({tag, "_valid"}, 32'(bus.grant_valid), 32'(v));
        check_eq({tag, "_timeout"}, 32'(bus.timeout), 32'(to));
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.req    = 8'hFF;
        bus.rel    = 1'b0;

        // Reset dominates active requests.
        expect_out("rst0", 8'h00, 3'd0, 1'b0, 1'b0);
        expect_out("rst1", 8'h00, 3'd0, 1'b0, 1'b0);

        // Single request, then release; ptr moves to 6.
        drive(1'b0, 1'b1, 8'h20, 1'b0); expect_out("single", 8'h20, 3'd5, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h20, 1'b1); expect_out("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h61, 1'b0); expect_out("ptr6", 8'h40, 3'd6, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0); expect_out("ptr6_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Wrap 7 -> 0.
        drive(1'b0, 1'b1, 8'h81, 1'b0); expect_out("wrap7", 8'h80, 3'd7, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h81, 1'b1); expect_out("wrap7_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h81, 1'b0); expect_out("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0); expect_out("wrap0_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // Timeout after MAX_HOLD cycles, then regrant after one idle cycle.
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("to_c1", 8'h04, 3'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("to_c2", 8'h04, 3'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("to_c3", 8'h04, 3'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("to_end", 8'h00, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("to_regrant", 8'h04, 3'd2, 1'b1, 1'b0);

        // Release in the expiry cycle suppresses the timeout pulse.
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("pre_c2", 8'h04, 3'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h04, 1'b0); expect_out("pre_c3", 8'h04, 3'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h04, 1'b1); expect_out("pre_end", 8'h00, 3'd0, 1'b0, 1'b0);

        // Enable drops mid-grant.
        drive(1'b0, 1'b1, 8'h08, 1'b0); expect_out("en_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h08, 1'b0); expect_out("en_abort", 8'h00, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h08, 1'b0); expect_out("en_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset mid-grant; ptr returns to 0 (checked by rotation start).
        drive(1'b0, 1'b1, 8'h40, 1'b0); expect_out("rm_grant", 8'h40, 3'd6, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 8'h40, 1'b0); expect_out("rm_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0); expect_out("rm_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Rotation with all requesting: 0,1,...,7,0 with one idle between.
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b1, 8'hFF, 1'b0);
            expect_out($sformatf("rot%0d", k), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            drive(1'b0, 1'b1, 8'hFF, 1'b0);
            expect_out($sformatf("rot%0d_hold", k), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            drive(1'b0, 1'b1, 8'hFF, 1'b1);
            expect_out($sformatf("rot%0d_idle", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        drive(1'b0, 1'b1, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
